// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding controller for the 5-stage RV32I core.
// Resolves load-use and branch hazards and runs a data-memory wait FSM with timeout.
// Optional feature macro: HAZARD_PERF_EN adds saturating performance counters.
// Handshake: the memory access in M is a req/ack pair; MemReqM is held while the
// instruction sits in M, and dmem_ack pulses high in the cycle the access completes.
// The pipeline is released in that same cycle.
module hazard_ctrl #(
  parameter int word_width = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ack,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [1:0]       dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lw_cnt
`endif
);

  // Wait counter is at least 5 bits and always wide enough to hold TIMEOUT.
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  // Elaboration-time sanity hook on the parameters; intentionally empty.
  if (word_width < 1 || CNT_W < 1 || TIMEOUT < 2) begin : g_bad_params
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } mem_state_t;

  mem_state_t      r_state, w_state_nxt;
  logic [CW-1:0]   r_wcnt, w_wcnt_nxt;
  logic            w_lw_stall;
  logic            w_mem_stall;

  // Operand forwarding: the younger result in M wins over W; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  // Load-use detection: a load in E whose result is consumed by the instruction in D.
  always_comb begin
    w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Memory wait FSM next-state logic; memStall falls in the same cycle the ack arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_mem_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReqM && !dmem_ack) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = CW'(1);
          w_mem_stall = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
        end else begin
          w_mem_stall = 1'b1;
          if (r_wcnt == CW'(TIMEOUT - 1)) w_state_nxt = S_ERR;
          else                            w_wcnt_nxt  = r_wcnt + CW'(1);
        end
      end
      S_ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Memory wait FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Stall/flush combination: a memory stall freezes everything and defers branch and
  // load-use flushes; a taken branch flushes D even while D is held by a load-use stall.
  always_comb begin
    StallF    = w_lw_stall | w_mem_stall;
    StallD    = w_lw_stall | w_mem_stall;
    StallE    = w_mem_stall;
    StallM    = w_mem_stall;
    FlushW    = w_mem_stall;
    FlushD    = PCSrcE & ~w_mem_stall;
    FlushE    = (w_lw_stall | PCSrcE) & ~w_mem_stall;
    mem_err   = (r_state == S_ERR);
    dbg_state = r_state;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cyc, r_flush_cnt, r_lw_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
      r_lw_cnt    <= '0;
    end else begin
      if (StallF && r_stall_cyc != '1)                   r_stall_cyc <= r_stall_cyc + 1'b1;
      if (FlushD && r_flush_cnt != '1)                   r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_lw_stall && !w_mem_stall && r_lw_cnt != '1)  r_lw_cnt    <= r_lw_cnt + 1'b1;
    end
  end

  assign perf_stall_cyc = r_stall_cyc;
  assign perf_flush_cnt = r_flush_cnt;
  assign perf_lw_cnt    = r_lw_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven combinational vectors plus hand-written memory-wait,
// timeout and reset sequences for hazard_ctrl.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ack;
  logic [1:0] ForwardAE, ForwardBE, dbg_state;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef HAZARD_PERF_EN
  localparam int PW = 3;
  logic [PW-1:0] perf_stall_cyc, perf_flush_cnt, perf_lw_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and reset
  always #5 clk = ~clk;

  hazard_ctrl #(
    .word_width(32), .TIMEOUT(16)
`ifdef HAZARD_PERF_EN
    , .CNT_W(PW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ack(dmem_ack),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
    .perf_lw_cnt(perf_lw_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld_e, rw_m, rw_w, pcsrc;
    logic [1:0] fa, fb;
    logic       stall_fd, stall_em, flush_d, flush_e, flush_w;
  } vec_t;

  vec_t tbl[13];

  // Packed view of every hazard output: {FA,FB,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [10:0] out_vec();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ack} = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name, rs1d rs2d rs1e rs2e rde rdm rdw, ld rwm rww pc, fa fb, sFD sEM fD fE fW
    tbl[0]  = '{"fwdA_M",      0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0};
    tbl[1]  = '{"fwdA_W",      0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0};
    tbl[2]  = '{"fwdA_x0",     0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[3]  = '{"fwdB_M",      0, 0, 0, 9, 0, 9, 9, 0, 1, 1, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0};
    tbl[4]  = '{"fwdB_W",      0, 0, 0, 9, 0, 3, 9, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0};
    tbl[5]  = '{"fwd_W_x0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[6]  = '{"fwdAB_M",     0, 0, 4, 4, 0, 4, 0, 0, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, 0};
    tbl[7]  = '{"lw_rs2",      0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0};
    tbl[8]  = '{"lw_rd0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[9]  = '{"no_load",     7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
    tbl[10] = '{"lw_rs1",      3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0};
    tbl[11] = '{"branch",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1, 0};
    tbl[12] = '{"branch_lw",   2, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1, 1, 0};

    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_state",   {30'd0, dbg_state}, 32'd0);
    check("reset_mem_err", {31'd0, mem_err},   32'd0);
    rst_n = 1'b1;
    #5;

    // Combinational table (memory idle throughout)
    for (int i = 0; i < 13; i++) begin
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      ResultSrcE0 = tbl[i].ld_e; RegWriteM = tbl[i].rw_m; RegWriteW = tbl[i].rw_w;
      PCSrcE = tbl[i].pcsrc; MemReqM = 1'b0; dmem_ack = 1'b0;
      #2;
      check(tbl[i].name, {21'd0, out_vec()},
            {21'd0, tbl[i].fa, tbl[i].fb, tbl[i].stall_fd, tbl[i].stall_fd,
             tbl[i].stall_em, tbl[i].stall_em, tbl[i].flush_d, tbl[i].flush_e,
             tbl[i].flush_w});
      #3;
    end
    clear_inputs();

    // Zero-wait access: ack in the request cycle, no stall, FSM stays idle
    cyc();
    MemReqM = 1'b1; dmem_ack = 1'b1;
    #1;
    check("zero_wait_nostall", {21'd0, out_vec()}, 32'd0);
    cyc();
    check("zero_wait_idle", {30'd0, dbg_state}, 32'd0);

    // Three-cycle memory wait, branch during the wait must not flush
    MemReqM = 1'b1; dmem_ack = 1'b0;
    #1;
    check("wait_c0", {21'd0, out_vec()}, {21'd0, 11'b0000_1111_001});
    cyc();
    PCSrcE = 1'b1;
    #1;
    check("wait_c1_branch", {21'd0, out_vec()}, {21'd0, 11'b0000_1111_001});
    check("wait_c1_state", {30'd0, dbg_state}, 32'd1);
    cyc();
    PCSrcE = 1'b0;
    #1;
    check("wait_c2", {21'd0, out_vec()}, {21'd0, 11'b0000_1111_001});
    cyc();
    dmem_ack = 1'b1;
    #1;
    check("ack_release", {21'd0, out_vec()}, 32'd0);
    cyc();
    MemReqM = 1'b0; dmem_ack = 1'b0;
    #1;
    check("ack_idle", {30'd0, dbg_state}, 32'd0);

    // Timeout: no ack for TIMEOUT cycles reaches the sticky error state
    MemReqM = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("to_stall_%0d", k), {30'd0, StallM, mem_err}, 32'd2);
      cyc();
    end
    check("to_mem_err", {31'd0, mem_err}, 32'd1);
    MemReqM = 1'b0; dmem_ack = 1'b1; PCSrcE = 1'b1;
    #1;
    check("err_stuck", {21'd0, out_vec()}, {21'd0, 11'b0000_1111_001});
    cyc();
    check("err_sticky", {31'd0, mem_err}, 32'd1);
    clear_inputs();

    // Reset clears the error; then reset asserted mid-wait discards the access
    rst_n = 1'b0;
    #2;
    check("rst_clears_err", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    cyc();
    MemReqM = 1'b1;
    cyc();
    cyc();
    check("midwait_state", {30'd0, dbg_state}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midwait_rst_idle", {30'd0, dbg_state}, 32'd0);
    check("midwait_rst_err",  {31'd0, mem_err},   32'd0);
    MemReqM = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
    check("post_rst_idle", {30'd0, dbg_state}, 32'd0);

`ifdef HAZARD_PERF_EN
    // Performance counters: two load-use cycles plus a three-cycle memory wait
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    check("perf_reset", {23'd0, perf_stall_cyc, perf_flush_cnt, perf_lw_cnt}, 32'd0);
    ResultSrcE0 = 1'b1; RdE = 5'd6; Rs1D = 5'd6;
    cyc();
    cyc();
    clear_inputs();
    MemReqM = 1'b1;
    cyc();
    cyc();
    cyc();
    dmem_ack = 1'b1;
    cyc();
    clear_inputs();
    #1;
    check("perf_stall_cyc", {29'd0, perf_stall_cyc}, 32'd5);
    check("perf_lw_cnt",    {29'd0, perf_lw_cnt},    32'd2);
    check("perf_flush_cnt", {29'd0, perf_flush_cnt}, 32'd0);
    ResultSrcE0 = 1'b1; RdE = 5'd6; Rs1D = 5'd6; PCSrcE = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    clear_inputs();
    #1;
    check("perf_sat_stall", {29'd0, perf_stall_cyc}, 32'd7);
    check("perf_sat_lw",    {29'd0, perf_lw_cnt},    32'd7);
    check("perf_sat_flush", {29'd0, perf_flush_cnt}, 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
